// File: rtl/rrf_alloc_multi_pkg.sv
// rrf_alloc_multi_pkg
//   Shared defaults for the rename-register-file allocator slice.
//   RRF_NUM_DEF     : default RRF depth
//   RRF_SEL_DEF     : tag width matching the default depth
//   ALLOC_WIDTH_DEF : default maximum allocations per cycle
//   COM_WIDTH_DEF   : default maximum commits per cycle
package rrf_alloc_multi_pkg;

    localparam int RRF_NUM_DEF     = 64;
    localparam int RRF_SEL_DEF     = $clog2(RRF_NUM_DEF);
    localparam int ALLOC_WIDTH_DEF = 2;
    localparam int COM_WIDTH_DEF   = 2;

endpackage

// File: rtl/rrf_ptr_add.sv
// rrf_ptr_add
//   Modular pointer adder for a circular RRF of arbitrary depth.
//   ptr_i  : current pointer, always < RRF_NUM
//   inc_i  : increment, 0..RRF_NUM
//   sum_o  : (ptr_i + inc_i) mod RRF_NUM
//   wrap_o : 1 when the raw sum reached or passed RRF_NUM
module rrf_ptr_add
    import rrf_alloc_multi_pkg::*;
#(
    parameter  int RRF_NUM = RRF_NUM_DEF,
    localparam int SEL     = $clog2(RRF_NUM)
) (
    input  logic [SEL-1:0] ptr_i,
    input  logic [SEL:0]   inc_i,
    output logic [SEL-1:0] sum_o,
    output logic           wrap_o
);

    localparam logic [SEL:0] DEPTH = (SEL + 1)'(RRF_NUM);

    // ptr < RRF_NUM and inc <= RRF_NUM, so the raw sum fits in SEL+1 bits
    // and a single conditional subtract gives the modulus.
    logic [SEL:0] raw;

    assign raw    = {1'b0, ptr_i} + inc_i;
    assign wrap_o = (raw >= DEPTH);
    assign sum_o  = wrap_o ? SEL'(raw - DEPTH) : raw[SEL-1:0];

endmodule

// File: rtl/rrf_alloc_multi.sv
// rrf_alloc_multi
//   Multi-issue RRF tag allocator: hands out up to ALLOC_WIDTH consecutive
//   tags per cycle, reclaims up to COM_WIDTH entries per cycle, restores
//   the allocation pointer to the commit pointer on flush.
//   clk, reset            : clock, synchronous active-high reset
//   req_num_i             : tags requested this cycle
//   com_inst_num_i        : entries committed this cycle
//   stall_dp_i, flush_i   : DP stall, misprediction recovery
//   rrf_allocatable_o     : free entries (plus same-cycle commits) cover request
//   alloc_fire_o          : allocation happens this cycle
//   dst_rename_rrftag_o   : slot k = (rrfptr + k) mod RRF_NUM
//   dst_tag_vld_o         : slot k valid
//   freenum_o, rrfptr_o, comptr_o : registered free count / pointers
//   nextrrfcyc_o          : allocation in the previous cycle wrapped rrfptr
//   err_o                 : sticky over-commit flag
module rrf_alloc_multi
    import rrf_alloc_multi_pkg::*;
#(
    parameter  int RRF_NUM     = RRF_NUM_DEF,
    parameter  int ALLOC_WIDTH = ALLOC_WIDTH_DEF,
    parameter  int COM_WIDTH   = COM_WIDTH_DEF,
    localparam int SEL         = $clog2(RRF_NUM),
    localparam int AW          = $clog2(ALLOC_WIDTH + 1),
    localparam int CW          = $clog2(COM_WIDTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              req_num_i,
    input  logic [CW-1:0]              com_inst_num_i,
    input  logic                       stall_dp_i,
    input  logic                       flush_i,
    output logic                       rrf_allocatable_o,
    output logic                       alloc_fire_o,
    output logic [ALLOC_WIDTH*SEL-1:0] dst_rename_rrftag_o,
    output logic [ALLOC_WIDTH-1:0]     dst_tag_vld_o,
    output logic [SEL:0]               freenum_o,
    output logic [SEL-1:0]             rrfptr_o,
    output logic [SEL-1:0]             comptr_o,
    output logic                       nextrrfcyc_o,
    output logic                       err_o
);

    // Wide enough for freenum + commit count without overflow.
    localparam int            WW      = ((SEL + 1 > CW) ? SEL + 1 : CW) + 1;
    localparam logic [WW-1:0] DEPTH_W = WW'(RRF_NUM);
    localparam logic [SEL:0]  DEPTH_F = (SEL + 1)'(RRF_NUM);

    logic [SEL:0]   freenum_q, freenum_d;
    logic [SEL-1:0] rrfptr_q, comptr_q;
    logic           nextrrfcyc_q, err_q;

    logic [WW-1:0]  free_w, used_w, com_w, req_w, freed_w, credit_w;
    logic           over_commit;
    logic [SEL:0]   req_inc, freed_inc;
    logic [SEL-1:0] rrf_sum, com_sum;
    logic           rrf_wrap;
    logic           unused_com_wrap;
    logic [ALLOC_WIDTH-1:0] unused_tag_wrap;

    assign free_w  = WW'(freenum_q);
    assign used_w  = DEPTH_W - free_w;
    assign com_w   = WW'(com_inst_num_i);
    assign req_w   = WW'(req_num_i);

    // Commits beyond the occupied count are clamped, so freenum saturates
    // at RRF_NUM and comptr never overtakes rrfptr.
    assign over_commit = (com_w > used_w);
    assign freed_w     = over_commit ? used_w : com_w;
    assign credit_w    = free_w + freed_w;

    assign rrf_allocatable_o = (credit_w >= req_w);
    assign alloc_fire_o      = !stall_dp_i && !flush_i && rrf_allocatable_o && (req_num_i != '0);

    assign freenum_d = alloc_fire_o ? (SEL + 1)'(credit_w - req_w) : (SEL + 1)'(credit_w);
    assign req_inc   = (SEL + 1)'(req_num_i);
    assign freed_inc = (SEL + 1)'(freed_w);

    rrf_ptr_add #(.RRF_NUM(RRF_NUM)) u_rrfptr_add (
        .ptr_i  (rrfptr_q),
        .inc_i  (req_inc),
        .sum_o  (rrf_sum),
        .wrap_o (rrf_wrap)
    );

    rrf_ptr_add #(.RRF_NUM(RRF_NUM)) u_comptr_add (
        .ptr_i  (comptr_q),
        .inc_i  (freed_inc),
        .sum_o  (com_sum),
        .wrap_o (unused_com_wrap)
    );

    for (genvar k = 0; k < ALLOC_WIDTH; k++) begin : g_tag
        rrf_ptr_add #(.RRF_NUM(RRF_NUM)) u_tag_add (
            .ptr_i  (rrfptr_q),
            .inc_i  ((SEL + 1)'(k)),
            .sum_o  (dst_rename_rrftag_o[k*SEL +: SEL]),
            .wrap_o (unused_tag_wrap[k])
        );
        assign dst_tag_vld_o[k] = alloc_fire_o && (AW'(k) < req_num_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freenum_q    <= DEPTH_F;
            rrfptr_q     <= '0;
            comptr_q     <= '0;
            nextrrfcyc_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (flush_i) begin
            // Flush-cycle commits are retired first, then every
            // uncommitted entry is released.
            freenum_q    <= DEPTH_F;
            rrfptr_q     <= com_sum;
            comptr_q     <= com_sum;
            nextrrfcyc_q <= 1'b0;
            err_q        <= err_q | over_commit;
        end else begin
            freenum_q    <= freenum_d;
            comptr_q     <= com_sum;
            err_q        <= err_q | over_commit;
            if (alloc_fire_o) begin
                rrfptr_q     <= rrf_sum;
                nextrrfcyc_q <= rrf_wrap;
            end else begin
                nextrrfcyc_q <= 1'b0;
            end
        end
    end

    assign freenum_o    = freenum_q;
    assign rrfptr_o     = rrfptr_q;
    assign comptr_o     = comptr_q;
    assign nextrrfcyc_o = nextrrfcyc_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_rrf_alloc_multi.sv
module tb_rrf_alloc_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req = '0;
    logic [2:0] com = '0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;

    // index 0: RRF_NUM=64, index 1: RRF_NUM=48 (both SEL=6)
    logic        o_alloc[2], o_fire[2], o_cyc[2], o_err[2];
    logic [11:0] o_tags[2];
    logic [1:0]  o_vld[2];
    logic [6:0]  o_free[2];
    logic [5:0]  o_rr[2], o_cp[2];

    int errors = 0;
    int checks = 0;

    // Reference model: oldest entry (head) and occupancy; rrfptr is derived.
    int mN[2] = '{64, 48};
    int mhead[2];
    int mused[2];
    bit merr[2];
    bit mcyc[2];

    always #5 clk = ~clk;

    rrf_alloc_multi #(.RRF_NUM(64), .ALLOC_WIDTH(2), .COM_WIDTH(2)) u_dut64 (
        .clk(clk), .reset(reset), .req_num_i(req), .com_inst_num_i(com[1:0]),
        .stall_dp_i(stall), .flush_i(flush),
        .rrf_allocatable_o(o_alloc[0]), .alloc_fire_o(o_fire[0]),
        .dst_rename_rrftag_o(o_tags[0]), .dst_tag_vld_o(o_vld[0]),
        .freenum_o(o_free[0]), .rrfptr_o(o_rr[0]), .comptr_o(o_cp[0]),
        .nextrrfcyc_o(o_cyc[0]), .err_o(o_err[0])
    );

    rrf_alloc_multi #(.RRF_NUM(48), .ALLOC_WIDTH(2), .COM_WIDTH(4)) u_dut48 (
        .clk(clk), .reset(reset), .req_num_i(req), .com_inst_num_i(com),
        .stall_dp_i(stall), .flush_i(flush),
        .rrf_allocatable_o(o_alloc[1]), .alloc_fire_o(o_fire[1]),
        .dst_rename_rrftag_o(o_tags[1]), .dst_tag_vld_o(o_vld[1]),
        .freenum_o(o_free[1]), .rrfptr_o(o_rr[1]), .comptr_o(o_cp[1]),
        .nextrrfcyc_o(o_cyc[1]), .err_o(o_err[1])
    );

    function automatic bit exp_alloc(int d);
        return (mN[d] - mused[d] + int'(com)) >= int'(req);
    endfunction

    function automatic bit exp_fire(int d);
        return !stall && !flush && (req != 0) && exp_alloc(d);
    endfunction

    function automatic int exp_rr(int d);
        return (mhead[d] + mused[d]) % mN[d];
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n = mN[d];
            int rr = exp_rr(d);
            bit fire = exp_fire(d);
            int freed = (int'(com) > mused[d]) ? mused[d] : int'(com);
            if (reset) begin
                mhead[d] = 0; mused[d] = 0; merr[d] = 0; mcyc[d] = 0;
            end else begin
                if (int'(com) > mused[d]) merr[d] = 1;
                mhead[d] = (mhead[d] + freed) % n;
                if (flush) begin
                    mused[d] = 0;
                    mcyc[d]  = 0;
                end else begin
                    mused[d] = mused[d] - freed;
                    if (fire) begin
                        mused[d] = mused[d] + int'(req);
                        mcyc[d]  = (rr + int'(req) >= n);
                    end else begin
                        mcyc[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; com = '0; stall = 1'b0; flush = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (o_free[0] !== 7'd64) begin errors++; $display("FAIL reset_free64: got %0d want 64", o_free[0]); end
        checks++;
        if (o_free[1] !== 7'd48) begin errors++; $display("FAIL reset_free48: got %0d want 48", o_free[1]); end
        checks++;
        if (o_rr[0] !== 6'd0 || o_cp[0] !== 6'd0) begin
            errors++; $display("FAIL reset_ptrs: got rr=%0d cp=%0d want 0/0", o_rr[0], o_cp[0]);
        end
        checks++;
        if (o_cyc[0] !== 1'b0 || o_err[0] !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got cyc=%0b err=%0b want 0/0", o_cyc[0], o_err[0]);
        end
        checks++;
    endtask

    task automatic test_first_alloc();
        do_reset();
        req = 2'd2;
        #1;
        if (o_fire[0] !== 1'b1 || o_vld[0] !== 2'b11) begin
            errors++; $display("FAIL first_fire: got fire=%0b vld=%b want 1/11", o_fire[0], o_vld[0]);
        end
        checks++;
        if (o_tags[0] !== {6'd1, 6'd0}) begin
            errors++; $display("FAIL first_tags: got %h want %h", o_tags[0], {6'd1, 6'd0});
        end
        checks++;
        tick();
        req = '0;
        if (o_rr[0] !== 6'd2 || o_free[0] !== 7'd62) begin
            errors++; $display("FAIL first_update: got rr=%0d free=%0d want 2/62", o_rr[0], o_free[0]);
        end
        checks++;
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            req = 2'd2;
            #1;
            if (i == 31) begin
                if (o_tags[0] !== {6'd63, 6'd62} || o_vld[0] !== 2'b11) begin
                    errors++; $display("FAIL fill_last_tags: got %h vld=%b want %h/11", o_tags[0], o_vld[0], {6'd63, 6'd62});
                end
                checks++;
            end
            tick();
        end
        if (o_rr[0] !== 6'd0 || o_cyc[0] !== 1'b1 || o_free[0] !== 7'd0) begin
            errors++; $display("FAIL fill_wrap: got rr=%0d cyc=%0b free=%0d want 0/1/0", o_rr[0], o_cyc[0], o_free[0]);
        end
        checks++;
        req = 2'd1; com = '0;
        #1;
        if (o_alloc[0] !== 1'b0 || o_fire[0] !== 1'b0) begin
            errors++; $display("FAIL full_blocked: got alloc=%0b fire=%0b want 0/0", o_alloc[0], o_fire[0]);
        end
        checks++;
        tick();
        if (o_cyc[0] !== 1'b0 || o_rr[0] !== 6'd0) begin
            errors++; $display("FAIL cyc_pulse: got cyc=%0b rr=%0d want 0/0", o_cyc[0], o_rr[0]);
        end
        checks++;
    endtask

    // Continues from the full state left by test_fill_wrap.
    task automatic test_credit();
        req = 2'd2; com = 3'd2;
        #1;
        if (o_fire[0] !== 1'b1 || o_tags[0] !== {6'd1, 6'd0}) begin
            errors++; $display("FAIL credit_fire: got fire=%0b tags=%h want 1/%h", o_fire[0], o_tags[0], {6'd1, 6'd0});
        end
        checks++;
        tick();
        if (o_free[0] !== 7'd0 || o_cp[0] !== 6'd2 || o_rr[0] !== 6'd2) begin
            errors++; $display("FAIL credit_update: got free=%0d cp=%0d rr=%0d want 0/2/2", o_free[0], o_cp[0], o_rr[0]);
        end
        checks++;
    endtask

    task automatic test_stall();
        stall = 1'b1; req = 2'd2; com = 3'd1;
        #1;
        if (o_vld[0] !== 2'b00 || o_fire[0] !== 1'b0) begin
            errors++; $display("FAIL stall_vld: got vld=%b fire=%0b want 00/0", o_vld[0], o_fire[0]);
        end
        checks++;
        tick();
        stall = 1'b0; req = '0; com = '0;
        if (o_rr[0] !== 6'd2 || o_free[0] !== 7'd1 || o_cp[0] !== 6'd3) begin
            errors++; $display("FAIL stall_update: got rr=%0d free=%0d cp=%0d want 2/1/3", o_rr[0], o_free[0], o_cp[0]);
        end
        checks++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = 2'd2;
            tick();
        end
        req = '0; com = 3'd2;
        tick();
        req = 2'd2; com = 3'd2; flush = 1'b1;
        #1;
        if (o_fire[0] !== 1'b0 || o_vld[0] !== 2'b00) begin
            errors++; $display("FAIL flush_fire: got fire=%0b vld=%b want 0/00", o_fire[0], o_vld[0]);
        end
        checks++;
        tick();
        flush = 1'b0; com = '0;
        if (o_rr[0] !== 6'd4 || o_cp[0] !== 6'd4 || o_free[0] !== 7'd64 || o_cyc[0] !== 1'b0) begin
            errors++; $display("FAIL flush_update: got rr=%0d cp=%0d free=%0d cyc=%0b want 4/4/64/0",
                               o_rr[0], o_cp[0], o_free[0], o_cyc[0]);
        end
        checks++;
        #1;
        if (o_tags[0] !== {6'd5, 6'd4} || o_fire[0] !== 1'b1) begin
            errors++; $display("FAIL post_flush_tags: got %h fire=%0b want %h/1", o_tags[0], o_fire[0], {6'd5, 6'd4});
        end
        checks++;
        tick();
        req = '0;
    endtask

    task automatic test_wrap48();
        do_reset();
        req = 2'd1; tick();
        req = 2'd2; tick();
        for (int i = 0; i < 22; i++) begin
            req = 2'd2; com = 3'd2; tick();
        end
        req = 2'd2; com = '0;
        #1;
        if (o_fire[1] !== 1'b1 || o_tags[1] !== {6'd0, 6'd47}) begin
            errors++; $display("FAIL wrap48_tags: got fire=%0b tags=%h want 1/%h", o_fire[1], o_tags[1], {6'd0, 6'd47});
        end
        checks++;
        tick();
        if (o_rr[1] !== 6'd1 || o_cyc[1] !== 1'b1 || o_free[1] !== 7'd43) begin
            errors++; $display("FAIL wrap48_update: got rr=%0d cyc=%0b free=%0d want 1/1/43", o_rr[1], o_cyc[1], o_free[1]);
        end
        checks++;
        req = '0; com = 3'd2; tick(); tick();
        if (o_cp[1] !== 6'd0 || o_free[1] !== 7'd47 || o_err[1] !== 1'b0) begin
            errors++; $display("FAIL wrap48_commit: got cp=%0d free=%0d err=%0b want 0/47/0", o_cp[1], o_free[1], o_err[1]);
        end
        checks++;
        com = 3'd3; tick();
        com = '0;
        if (o_err[1] !== 1'b1 || o_free[1] !== 7'd48 || o_cp[1] !== 6'd1 || o_rr[1] !== 6'd1) begin
            errors++; $display("FAIL overcommit48: got err=%0b free=%0d cp=%0d rr=%0d want 1/48/1/1",
                               o_err[1], o_free[1], o_cp[1], o_rr[1]);
        end
        checks++;
        if (o_err[0] !== 1'b1 || o_free[0] !== 7'd64) begin
            errors++; $display("FAIL overcommit64: got err=%0b free=%0d want 1/64", o_err[0], o_free[0]);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int lim;
            lim = (mused[0] < mused[1]) ? mused[0] : mused[1];
            if (lim > 2) lim = 2;
            req   = 2'($urandom_range(0, 2));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 99) == 0);
            com   = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, lim));
            #1;
            for (int d = 0; d < 2; d++) begin
                bit       ef = exp_fire(d);
                logic [1:0] ev;
                int       rr = exp_rr(d);
                ev = {ef && (req > 2'd1), ef && (req > 2'd0)};
                if (o_alloc[d] !== exp_alloc(d)) begin
                    errors++; $display("FAIL rnd_alloc d%0d i%0d: got %0b want %0b", d, i, o_alloc[d], exp_alloc(d));
                end
                checks++;
                if (o_fire[d] !== ef || o_vld[d] !== ev) begin
                    errors++; $display("FAIL rnd_fire d%0d i%0d: got fire=%0b vld=%b want %0b/%b", d, i, o_fire[d], o_vld[d], ef, ev);
                end
                checks++;
                for (int k = 0; k < 2; k++) begin
                    if (o_tags[d][k*6 +: 6] !== 6'((rr + k) % mN[d])) begin
                        errors++; $display("FAIL rnd_tag d%0d i%0d k%0d: got %0d want %0d",
                                           d, i, k, o_tags[d][k*6 +: 6], (rr + k) % mN[d]);
                    end
                    checks++;
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                if (o_free[d] !== 7'(mN[d] - mused[d]) || o_rr[d] !== 6'(exp_rr(d)) || o_cp[d] !== 6'(mhead[d])) begin
                    errors++; $display("FAIL rnd_state d%0d i%0d: got free=%0d rr=%0d cp=%0d want %0d/%0d/%0d",
                                       d, i, o_free[d], o_rr[d], o_cp[d], mN[d] - mused[d], exp_rr(d), mhead[d]);
                end
                checks++;
                if (o_cyc[d] !== mcyc[d] || o_err[d] !== merr[d]) begin
                    errors++; $display("FAIL rnd_flags d%0d i%0d: got cyc=%0b err=%0b want %0b/%0b",
                                       d, i, o_cyc[d], o_err[d], mcyc[d], merr[d]);
                end
                checks++;
            end
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; req = '0; com = '0;
    endtask

    task automatic test_reset_mid();
        req = 2'd2; com = 3'd3;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; req = '0; com = '0;
        if (o_free[0] !== 7'd64 || o_rr[0] !== 6'd0 || o_cp[0] !== 6'd0 || o_err[0] !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got free=%0d rr=%0d cp=%0d err=%0b want 64/0/0/0",
                               o_free[0], o_rr[0], o_cp[0], o_err[0]);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_first_alloc();
        test_fill_wrap();
        test_credit();
        test_stall();
        test_flush();
        test_wrap48();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
